convolution_procesor_index_sequencer: RTL and testbench
=======================================================

Name: convolution_procesor_index_sequencer

Overview:
Control sequencer for the convolution processor. It drives the loop indices that the less-than comparators and the MAC datapath consume, and it computes z[i] = sum over k of x[i-k]*y[k] for i = 0 .. sizeX+sizeY-2. It generates the X and Y memory read addresses, the MAC clear/enable strobes and the Z write strobe/address, under a start/busy/done handshake with the host interface.

Parameters:
ADDR_WIDTH_X, 5, address width of X memory; sizeX_i range 0..2^ADDR_WIDTH_X
ADDR_WIDTH_Y, 5, address width of Y memory; sizeY_i range 0..2^ADDR_WIDTH_Y
ADDR_WIDTH_Z, 6, address width of Z memory; must be >= max(ADDR_WIDTH_X, ADDR_WIDTH_Y)+1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start request, sampled only in IDLE
sizeX_i  in  ADDR_WIDTH_X+1  number of x samples
sizeY_i  in  ADDR_WIDTH_Y+1  number of y samples
memX_addr_o  out  ADDR_WIDTH_X  X read address (i-k)
memY_addr_o  out  ADDR_WIDTH_Y  Y read address (k)
memZ_addr_o  out  ADDR_WIDTH_Z  Z write address (i)
mac_clear_o  out  1  clear accumulator
mac_en_o  out  1  accumulate product of current X/Y reads
writeZ_o  out  1  write accumulator to Z at memZ_addr_o
sizeZ_o  out  ADDR_WIDTH_Z  latched sizeX+sizeY-1; 0 if either size is 0
busy_o  out  1  operation in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE. All outputs 0, including addresses and sizeZ_o. Reset mid-operation aborts immediately; no further writeZ_o is issued.
- States: IDLE, CLEAR, RUN, WRITE, DONE.
- IDLE: if start_i=1, latch sizeX/sizeY and set sizeZ_o.
  - If either size is 0, go to DONE. No mac/write strobes are issued.
  - Otherwise set i=0 and go to CLEAR.
- CLEAR (1 cycle): mac_clear_o=1.
  - Compute kLo = (i < sizeX) ? 0 : i-sizeX+1.
  - Compute kHi = (i < sizeY-1) ? i : sizeY-1.
  - Set k=kLo. Next state RUN.
  - Bounds use unsigned less-than compares at width ADDR_WIDTH_Z.
- RUN (kHi-kLo+1 cycles, always >= 1): mac_en_o=1, memX_addr_o=i-k, memY_addr_o=k.
  - Increment k each cycle.
  - Leave to WRITE in the cycle where k==kHi.
- WRITE (1 cycle): writeZ_o=1, memZ_addr_o=i.
  - If i < sizeZ-1: i++, go to CLEAR.
  - Else go to DONE.
- DONE (1 cycle): done_o=1, then IDLE.
- busy_o=1 in CLEAR, RUN, WRITE and DONE; busy_o=0 in IDLE. done_o and busy_o are high together in DONE.
- Addresses are valid in the same cycle as mac_en_o. Any memory read latency is absorbed downstream. Addresses and memZ_addr_o hold their last values outside RUN/WRITE.
- Strobes mac_clear_o, mac_en_o, writeZ_o and done_o are registered and mutually exclusive.
- start_i while busy is ignored. start_i held high in DONE starts nothing until IDLE samples it.
- Size inputs may change while busy without effect; latched copies are used.
- Total cycles from the start edge to the done_o cycle: 2*sizeZ + sizeX*sizeY + 1.

Test Plan:
- sizeX=3, sizeY=2, start pulse -> (X,Y) pairs per i: i0 (0,0); i1 (1,0),(0,1); i2 (2,0),(1,1); i3 (2,1). writeZ at 0,1,2,3; sizeZ_o=4; done_o 15 cycles after the start edge.
- sizeX=1, sizeY=1 -> one CLEAR, one RUN (0,0), writeZ at Z=0, then done_o; sizeZ_o=1.
- sizeX=0, sizeY=5 -> done_o on the next cycle; no mac_en/writeZ; sizeZ_o=0.
- sizeX=32, sizeY=32 (full depth) -> 63 writeZ pulses at addresses 0..62; i=31 gives 32 mac_en cycles; i=62 gives exactly (31,31).
- start_i re-pulsed mid-run and sizeX_i changed -> sequence unchanged, no restart.
- rst_i asserted during RUN of i=2 -> next cycle all outputs 0, IDLE; a fresh start then runs a full sequence.

Source files
------------

// File: rtl/convolution_procesor_index_sequencer.sv
// -----------------------------------------------------------------------------
// convolution_procesor_index_sequencer
//
// Purpose: control sequencer for the convolution processor. It walks the
// output index i over 0 .. sizeX+sizeY-2 and, for each i, the tap index k over
// the range where both x[i-k] and y[k] exist. It issues the X/Y read
// addresses, the MAC clear/enable strobes, the Z write strobe/address, and a
// start/busy/done handshake with the host.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous reset, active-high
//   start_i      start request, only looked at while idle
//   sizeX_i      number of x samples (0 .. 2^ADDR_WIDTH_X)
//   sizeY_i      number of y samples (0 .. 2^ADDR_WIDTH_Y)
//   memX_addr_o  X read address (i-k)
//   memY_addr_o  Y read address (k)
//   memZ_addr_o  Z write address (i)
//   mac_clear_o  clear accumulator
//   mac_en_o     accumulate product of the current X/Y reads
//   writeZ_o     write accumulator to Z at memZ_addr_o
//   sizeZ_o      latched sizeX+sizeY-1, or 0 when either size is 0
//   busy_o       operation in progress
//   done_o       one-cycle completion pulse
//
// All outputs are registered and line up with the state register: the cycle
// in which the FSM sits in a state is the cycle its strobes are high.
// -----------------------------------------------------------------------------
module convolution_procesor_index_sequencer #(
    parameter int ADDR_WIDTH_X = 5,
    parameter int ADDR_WIDTH_Y = 5,
    parameter int ADDR_WIDTH_Z = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH_X:0]   sizeX_i,
    input  logic [ADDR_WIDTH_Y:0]   sizeY_i,
    output logic [ADDR_WIDTH_X-1:0] memX_addr_o,
    output logic [ADDR_WIDTH_Y-1:0] memY_addr_o,
    output logic [ADDR_WIDTH_Z-1:0] memZ_addr_o,
    output logic                    mac_clear_o,
    output logic                    mac_en_o,
    output logic                    writeZ_o,
    output logic [ADDR_WIDTH_Z-1:0] sizeZ_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int ZW = ADDR_WIDTH_Z;
    localparam logic [ZW-1:0] ZERO_Z = ZW'(0);
    localparam logic [ZW-1:0] ONE_Z  = ZW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [ZW-1:0]           i_q, i_d;
    logic [ZW-1:0]           k_q, k_d;
    logic [ZW-1:0]           khi_q, khi_d;
    logic [ZW-1:0]           sizex_q, sizex_d;
    logic [ZW-1:0]           sizey_q, sizey_d;
    logic [ZW-1:0]           sizez_q, sizez_d;
    logic [ADDR_WIDTH_X-1:0] memx_q, memx_d;
    logic [ADDR_WIDTH_Y-1:0] memy_q, memy_d;
    logic [ZW-1:0]           memz_q, memz_d;
    logic                    clear_q, clear_d;
    logic                    en_q, en_d;
    logic                    wr_q, wr_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic [ZW-1:0]           sx_in_s;
    logic [ZW-1:0]           sy_in_s;
    logic [ZW-1:0]           klo_s;
    logic [ZW-1:0]           khi_s;
    logic [ZW-1:0]           k_next_s;

    // Next-state and next-output logic for the sequencer FSM
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        k_d      = k_q;
        khi_d    = khi_q;
        sizex_d  = sizex_q;
        sizey_d  = sizey_q;
        sizez_d  = sizez_q;
        memx_d   = memx_q;
        memy_d   = memy_q;
        memz_d   = memz_q;
        clear_d  = 1'b0;
        en_d     = 1'b0;
        wr_d     = 1'b0;
        done_d   = 1'b0;

        sx_in_s  = ZW'(sizeX_i);
        sy_in_s  = ZW'(sizeY_i);
        // First valid tap: x index i-k must stay below sizeX.
        klo_s    = (i_q < sizex_q) ? ZERO_Z : (i_q - sizex_q + ONE_Z);
        // Last valid tap: k may not exceed i nor sizeY-1 (sizeY >= 1 here).
        khi_s    = (i_q < (sizey_q - ONE_Z)) ? i_q : (sizey_q - ONE_Z);
        k_next_s = k_q + ONE_Z;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    sizex_d = sx_in_s;
                    sizey_d = sy_in_s;
                    if ((sx_in_s == ZERO_Z) || (sy_in_s == ZERO_Z)) begin
                        sizez_d = ZERO_Z;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        sizez_d = sx_in_s + sy_in_s - ONE_Z;
                        i_d     = ZERO_Z;
                        state_d = ST_CLEAR;
                        clear_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                // Load the tap window and present the first read pair.
                k_d     = klo_s;
                khi_d   = khi_s;
                memx_d  = ADDR_WIDTH_X'(i_q - klo_s);
                memy_d  = ADDR_WIDTH_Y'(klo_s);
                en_d    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (k_q == khi_q) begin
                    memz_d  = i_q;
                    wr_d    = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    k_d     = k_next_s;
                    memx_d  = ADDR_WIDTH_X'(i_q - k_next_s);
                    memy_d  = ADDR_WIDTH_Y'(k_next_s);
                    en_d    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_WRITE: begin
                if (i_q < (sizez_q - ONE_Z)) begin
                    i_d     = i_q + ONE_Z;
                    clear_d = 1'b1;
                    state_d = ST_CLEAR;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, index and registered-output update with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            i_q     <= ZERO_Z;
            k_q     <= ZERO_Z;
            khi_q   <= ZERO_Z;
            sizex_q <= ZERO_Z;
            sizey_q <= ZERO_Z;
            sizez_q <= ZERO_Z;
            memx_q  <= {ADDR_WIDTH_X{1'b0}};
            memy_q  <= {ADDR_WIDTH_Y{1'b0}};
            memz_q  <= ZERO_Z;
            clear_q <= 1'b0;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            khi_q   <= khi_d;
            sizex_q <= sizex_d;
            sizey_q <= sizey_d;
            sizez_q <= sizez_d;
            memx_q  <= memx_d;
            memy_q  <= memy_d;
            memz_q  <= memz_d;
            clear_q <= clear_d;
            en_q    <= en_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign memX_addr_o = memx_q;
    assign memY_addr_o = memy_q;
    assign memZ_addr_o = memz_q;
    assign mac_clear_o = clear_q;
    assign mac_en_o    = en_q;
    assign writeZ_o    = wr_q;
    assign sizeZ_o     = sizez_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_convolution_procesor_index_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for convolution_procesor_index_sequencer.
// A table of {sizeX, sizeY, expected sizeZ, expected done cycle} records is
// applied in a loop. Per-cycle strobes and addresses are compared against an
// event list built from the convolution definition (all (i,k) with valid
// x[i-k] and y[k]). Hand-written sequences cover mid-run reset.
// -----------------------------------------------------------------------------
module tb_convolution_procesor_index_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [5:0] sizeX_i;
    logic [5:0] sizeY_i;
    logic [4:0] memX_addr_o;
    logic [4:0] memY_addr_o;
    logic [5:0] memZ_addr_o;
    logic       mac_clear_o;
    logic       mac_en_o;
    logic       writeZ_o;
    logic [5:0] sizeZ_o;
    logic       busy_o;
    logic       done_o;

    convolution_procesor_index_sequencer #(
        .ADDR_WIDTH_X(5),
        .ADDR_WIDTH_Y(5),
        .ADDR_WIDTH_Z(6)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .sizeX_i     (sizeX_i),
        .sizeY_i     (sizeY_i),
        .memX_addr_o (memX_addr_o),
        .memY_addr_o (memY_addr_o),
        .memZ_addr_o (memZ_addr_o),
        .mac_clear_o (mac_clear_o),
        .mac_en_o    (mac_en_o),
        .writeZ_o    (writeZ_o),
        .sizeZ_o     (sizeZ_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int sx;
        int sy;
        int exp_sz;
        int exp_cyc;
        bit glitch;
    } vec_t;

    typedef struct {
        int kind;   // 0 clear, 1 run, 2 write, 3 done
        int x;
        int y;
        int z;
    } ev_t;

    vec_t vecs[10];
    ev_t  evq[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int strobes();
        return int'({busy_o, mac_clear_o, mac_en_o, writeZ_o, done_o});
    endfunction

    // Expected per-cycle event list straight from z[i] = sum x[i-k]*y[k].
    task automatic build(input int sx, input int sy);
        ev_t e;
        evq.delete();
        if (sx != 0 && sy != 0) begin
            for (int i = 0; i <= sx + sy - 2; i++) begin
                e = '{kind: 0, x: 0, y: 0, z: 0};
                evq.push_back(e);
                for (int k = 0; k < sy; k++) begin
                    if ((i - k) >= 0 && (i - k) < sx) begin
                        e = '{kind: 1, x: i - k, y: k, z: 0};
                        evq.push_back(e);
                    end
                end
                e = '{kind: 2, x: 0, y: 0, z: i};
                evq.push_back(e);
            end
        end
        e = '{kind: 3, x: 0, y: 0, z: 0};
        evq.push_back(e);
    endtask

    // Compare one cycle's outputs against the expected event.
    task automatic check_event(input ev_t e);
        int exp_s;
        exp_s = {28'd0, 1'b1, e.kind == 0, e.kind == 1, e.kind == 2, e.kind == 3};
        chk("strobes", strobes(), exp_s);
        if (e.kind == 1) begin
            chk("memX", int'(memX_addr_o), e.x);
            chk("memY", int'(memY_addr_o), e.y);
        end else if (e.kind == 2) begin
            chk("memZ", int'(memZ_addr_o), e.z);
        end
    endtask

    task automatic run_op(input vec_t v);
        int done_at;
        build(v.sx, v.sy);
        @(negedge clk_i);
        start_i = 1'b1;
        sizeX_i = 6'(v.sx);
        sizeY_i = 6'(v.sy);
        @(negedge clk_i);
        start_i = 1'b0;
        chk("sizeZ", int'(sizeZ_o), v.exp_sz);
        done_at = -1;
        for (int c = 1; c <= evq.size(); c++) begin
            if (done_o && done_at < 0) done_at = c;
            check_event(evq[c-1]);
            if (v.glitch) begin
                start_i = ((c >= 2) && (c <= 6)) || (c == evq.size());
                sizeX_i = 6'd7;
            end
            @(negedge clk_i);
        end
        chk("done_cycle", done_at, v.exp_cyc);
        chk("idle_after", strobes(), 0);
        chk("sizeZ_hold", int'(sizeZ_o), v.exp_sz);
        start_i = 1'b0;
        @(negedge clk_i);
        chk("still_idle", strobes(), 0);
    endtask

    initial begin
        vec_t rv;
        vecs[0] = '{sx: 3,  sy: 2,  exp_sz: 4,  exp_cyc: 15,   glitch: 1'b0};
        vecs[1] = '{sx: 1,  sy: 1,  exp_sz: 1,  exp_cyc: 4,    glitch: 1'b0};
        vecs[2] = '{sx: 0,  sy: 5,  exp_sz: 0,  exp_cyc: 1,    glitch: 1'b0};
        vecs[3] = '{sx: 5,  sy: 0,  exp_sz: 0,  exp_cyc: 1,    glitch: 1'b0};
        vecs[4] = '{sx: 32, sy: 32, exp_sz: 63, exp_cyc: 1151, glitch: 1'b0};
        vecs[5] = '{sx: 4,  sy: 3,  exp_sz: 6,  exp_cyc: 25,   glitch: 1'b0};
        vecs[6] = '{sx: 2,  sy: 5,  exp_sz: 6,  exp_cyc: 23,   glitch: 1'b0};
        vecs[7] = '{sx: 32, sy: 1,  exp_sz: 32, exp_cyc: 97,   glitch: 1'b0};
        vecs[8] = '{sx: 1,  sy: 32, exp_sz: 32, exp_cyc: 97,   glitch: 1'b0};
        vecs[9] = '{sx: 3,  sy: 2,  exp_sz: 4,  exp_cyc: 15,   glitch: 1'b1};

        rst_i   = 1'b1;
        start_i = 1'b0;
        sizeX_i = 6'd0;
        sizeY_i = 6'd0;
        repeat (3) @(negedge clk_i);
        chk("reset_strobes", strobes(), 0);
        chk("reset_addr", int'({memX_addr_o, memY_addr_o, memZ_addr_o}), 0);
        chk("reset_sizeZ", int'(sizeZ_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_no_start", strobes(), 0);

        for (int n = 0; n < 10; n++) begin
            run_op(vecs[n]);
        end

        // Reset during RUN of i=2 (cycle 9 of a 3x2 operation).
        build(3, 2);
        @(negedge clk_i);
        start_i = 1'b1;
        sizeX_i = 6'd3;
        sizeY_i = 6'd2;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            check_event(evq[c-1]);
            if (c == 9) rst_i = 1'b1;
            @(negedge clk_i);
        end
        chk("rst_mid_strobes", strobes(), 0);
        chk("rst_mid_memX", int'(memX_addr_o), 0);
        chk("rst_mid_memY", int'(memY_addr_o), 0);
        chk("rst_mid_memZ", int'(memZ_addr_o), 0);
        chk("rst_mid_sizeZ", int'(sizeZ_o), 0);
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            chk("post_rst_idle", strobes(), 0);
        end
        rv = vecs[0];
        run_op(rv);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
